// File: rtl/rename_regfile.sv
// Architectural register file with a per-register rename tag (ROB nick).
// Dispatch reads two sources combinationally; each returns a value or the
// pending producer nick. Commits write data and retire matching tags; a
// flush drops every outstanding tag.
module rename_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NAME_W = 5,
  parameter int unsigned NICK_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iROB_clr,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [NAME_W-1:0] iROB_nick_regnm,
  input  logic              iRF_en,
  input  logic [NAME_W-1:0] iRF_rd_regnm,
  input  logic [DATA_W-1:0] iRF_rd_dt,
  input  logic [NICK_W-1:0] iRF_rd_nick,
  input  logic [NAME_W-1:0] iDP_rs1_regnm,
  input  logic [NAME_W-1:0] iDP_rs2_regnm,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  output logic [DATA_W-1:0] oDP_rs2_dt,
  output logic [NICK_W-1:0] oDP_rs2_nick,
  output logic [NAME_W:0]   oRF_busy_cnt
);

  localparam int unsigned NREG = 2 ** NAME_W;

  logic [DATA_W-1:0] r_dt  [NREG];
  logic [NICK_W-1:0] r_tag [NREG];
  logic [NAME_W:0]   r_busy_cnt;

  logic [DATA_W-1:0] w_dt_d  [NREG];
  logic [NICK_W-1:0] w_tag_d [NREG];
  logic [NAME_W:0]   w_busy_cnt_d;
  logic              w_commit;
  logic              w_rename;

  assign w_commit = iRF_en && (iRF_rd_regnm != '0);
  assign w_rename = iROB_nick_en && (iROB_nick_regnm != '0) && !iROB_clr;

  // Next-state data/tags: commit first, then flush or rename overrides the tag.
  always_comb begin
    w_dt_d  = r_dt;
    w_tag_d = r_tag;
    if (w_commit) begin
      w_dt_d[iRF_rd_regnm] = iRF_rd_dt;
      // A younger rename of the same register keeps its tag.
      if (r_tag[iRF_rd_regnm] == iRF_rd_nick) begin
        w_tag_d[iRF_rd_regnm] = '0;
      end
    end
    if (iROB_clr) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        w_tag_d[i] = '0;
      end
    end else if (w_rename) begin
      w_tag_d[iROB_nick_regnm] = iROB_nick;
    end
  end

  // Post-edge count of tagged registers.
  always_comb begin
    w_busy_cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (w_tag_d[i] != '0) begin
        w_busy_cnt_d = w_busy_cnt_d + (NAME_W + 1)'(1);
      end
    end
  end

  // State update, held while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dt       <= '{default: '0};
      r_tag      <= '{default: '0};
      r_busy_cnt <= '0;
    end else if (rdy) begin
      r_dt       <= w_dt_d;
      r_tag      <= w_tag_d;
      r_busy_cnt <= w_busy_cnt_d;
    end
  end

  assign oRF_busy_cnt = r_busy_cnt;

  // Source 1 lookup: x0 is hardwired, a matching commit bypasses the tag.
  always_comb begin
    oDP_rs1_dt   = r_dt[iDP_rs1_regnm];
    oDP_rs1_nick = r_tag[iDP_rs1_regnm];
    if (iDP_rs1_regnm == '0) begin
      oDP_rs1_dt   = '0;
      oDP_rs1_nick = '0;
    end else if ((r_tag[iDP_rs1_regnm] != '0) && iRF_en && (iRF_rd_regnm == iDP_rs1_regnm) &&
                 (r_tag[iDP_rs1_regnm] == iRF_rd_nick)) begin
      oDP_rs1_dt   = iRF_rd_dt;
      oDP_rs1_nick = '0;
    end
  end

  // Source 2 lookup, same rules as source 1.
  always_comb begin
    oDP_rs2_dt   = r_dt[iDP_rs2_regnm];
    oDP_rs2_nick = r_tag[iDP_rs2_regnm];
    if (iDP_rs2_regnm == '0) begin
      oDP_rs2_dt   = '0;
      oDP_rs2_nick = '0;
    end else if ((r_tag[iDP_rs2_regnm] != '0) && iRF_en && (iRF_rd_regnm == iDP_rs2_regnm) &&
                 (r_tag[iDP_rs2_regnm] == iRF_rd_nick)) begin
      oDP_rs2_dt   = iRF_rd_dt;
      oDP_rs2_nick = '0;
    end
  end

  // Nick 0 means "ready" and must never be allocated.
  a_nick_nonzero: assert property (@(posedge clk) disable iff (!rst)
    (rdy && iROB_nick_en) |-> (iROB_nick != '0));

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: a table of per-cycle stimulus with
// hand-computed read results and busy count, plus an async-reset sequence.
module tb_rename_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        iROB_clr;
  logic        iROB_nick_en;
  logic [4:0]  iROB_nick;
  logic [4:0]  iROB_nick_regnm;
  logic        iRF_en;
  logic [4:0]  iRF_rd_regnm;
  logic [31:0] iRF_rd_dt;
  logic [4:0]  iRF_rd_nick;
  logic [4:0]  iDP_rs1_regnm;
  logic [4:0]  iDP_rs2_regnm;
  logic [31:0] oDP_rs1_dt;
  logic [4:0]  oDP_rs1_nick;
  logic [31:0] oDP_rs2_dt;
  logic [4:0]  oDP_rs2_nick;
  logic [5:0]  oRF_busy_cnt;

  rename_regfile #(
    .DATA_W(32),
    .NAME_W(5),
    .NICK_W(5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .iROB_clr       (iROB_clr),
    .iROB_nick_en   (iROB_nick_en),
    .iROB_nick      (iROB_nick),
    .iROB_nick_regnm(iROB_nick_regnm),
    .iRF_en         (iRF_en),
    .iRF_rd_regnm   (iRF_rd_regnm),
    .iRF_rd_dt      (iRF_rd_dt),
    .iRF_rd_nick    (iRF_rd_nick),
    .iDP_rs1_regnm  (iDP_rs1_regnm),
    .iDP_rs2_regnm  (iDP_rs2_regnm),
    .oDP_rs1_dt     (oDP_rs1_dt),
    .oDP_rs1_nick   (oDP_rs1_nick),
    .oDP_rs2_dt     (oDP_rs2_dt),
    .oDP_rs2_nick   (oDP_rs2_nick),
    .oRF_busy_cnt   (oRF_busy_cnt)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; expected values are the combinational reads seen
  // before the edge and the busy count registered by the previous edge.
  typedef struct {
    logic [31:0] ne, nk, nr;
    logic [31:0] ce, cr, cd, cn;
    logic [31:0] clr, rdy;
    logic [31:0] rs1, rs2;
    logic [31:0] e1d, e1n, e2d, e2n, eb;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    iROB_nick_en    = v.ne[0];
    iROB_nick       = v.nk[4:0];
    iROB_nick_regnm = v.nr[4:0];
    iRF_en          = v.ce[0];
    iRF_rd_regnm    = v.cr[4:0];
    iRF_rd_dt       = v.cd;
    iRF_rd_nick     = v.cn[4:0];
    iROB_clr        = v.clr[0];
    rdy             = v.rdy[0];
    iDP_rs1_regnm   = v.rs1[4:0];
    iDP_rs2_regnm   = v.rs2[4:0];
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e1d, input logic [31:0] e1n,
                            input logic [31:0] e2d, input logic [31:0] e2n,
                            input logic [31:0] eb);
    check({tag, ".rs1_dt"}, oDP_rs1_dt, e1d);
    check({tag, ".rs1_nick"}, 32'(oDP_rs1_nick), e1n);
    check({tag, ".rs2_dt"}, oDP_rs2_dt, e2d);
    check({tag, ".rs2_nick"}, 32'(oDP_rs2_nick), e2n);
    check({tag, ".busy_cnt"}, 32'(oRF_busy_cnt), eb);
  endtask

  function automatic vec_t mk(input int ne, nk, nr, ce, cr, input logic [31:0] cd,
                              input int cn, clr, rd, rs1, rs2,
                              input logic [31:0] e1d, input int e1n,
                              input logic [31:0] e2d, input int e2n, input int eb);
    vec_t v;
    v.ne = ne;  v.nk = nk;  v.nr = nr;
    v.ce = ce;  v.cr = cr;  v.cd = cd;  v.cn = cn;
    v.clr = clr; v.rdy = rd;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e1d = e1d; v.e1n = e1n; v.e2d = e2d; v.e2n = e2n; v.eb = eb;
    return v;
  endfunction

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    rst = 1'b0;

    //             ne nk nr ce cr cd            cn clr rdy rs1 rs2 e1d           e1n e2d           e2n eb
    // Reset then read
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 5, 0, 0,            0, 0,            0, 0));
    // Rename x5->3, then commit with bypass
    vq.push_back(mk(1, 3, 5, 0, 0, 0,            0, 0, 1, 5, 0, 0,            0, 0,            0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 5, 0, 0,            3, 0,            0, 1));
    vq.push_back(mk(0, 0, 0, 1, 5, 32'hDEADBEEF, 3, 0, 1, 5, 0, 32'hDEADBEEF, 0, 0,            0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 5, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0));
    // Stale commit on x7
    vq.push_back(mk(1, 4, 7, 0, 0, 0,            0, 0, 1, 7, 0, 0,            0, 0,            0, 0));
    vq.push_back(mk(1, 9, 7, 0, 0, 0,            0, 0, 1, 7, 0, 0,            4, 0,            0, 1));
    vq.push_back(mk(0, 0, 0, 1, 7, 32'h11,       4, 0, 1, 7, 0, 0,            9, 0,            0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 7, 0, 32'h11,       9, 0,            0, 1));
    vq.push_back(mk(0, 0, 0, 1, 7, 32'h22,       9, 0, 1, 7, 0, 32'h22,       0, 0,            0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 7, 0, 32'h22,       0, 0,            0, 0));
    // Simultaneous rename and commit on x2
    vq.push_back(mk(1, 6, 2, 0, 0, 0,            0, 0, 1, 2, 0, 0,            0, 0,            0, 0));
    vq.push_back(mk(1, 7, 2, 1, 2, 32'h55,       6, 0, 1, 2, 7, 32'h55,       0, 32'h22,       0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 2, 0, 32'h55,       7, 0,            0, 1));
    // Flush with commit and dropped rename
    vq.push_back(mk(1, 2, 1, 0, 0, 0,            0, 0, 1, 2, 1, 32'h55,       7, 0,            0, 1));
    vq.push_back(mk(1, 5, 3, 0, 0, 0,            0, 0, 1, 1, 0, 0,            2, 0,            0, 2));
    vq.push_back(mk(1, 8, 4, 0, 0, 0,            0, 0, 1, 3, 1, 0,            5, 0,            2, 3));
    vq.push_back(mk(1, 10, 6, 1, 1, 32'hAA,      2, 1, 1, 1, 4, 32'hAA,       0, 0,            8, 4));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 1, 6, 32'hAA,       0, 0,            0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 4, 2, 0,            0, 32'h55,       0, 0));
    // x0 ignores rename and commit
    vq.push_back(mk(1, 12, 0, 1, 0, 32'hFF,      12, 0, 1, 0, 0, 0,           0, 0,            0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0,            0, 0,            0, 0));
    // rdy low holds state
    vq.push_back(mk(1, 1, 9, 0, 0, 0,            0, 0, 0, 9, 0, 0,            0, 0,            0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 9, 0, 0,            0, 0,            0, 0));
    vq.push_back(mk(1, 1, 9, 0, 0, 0,            0, 0, 1, 9, 0, 0,            0, 0,            0, 0));
    vq.push_back(mk(0, 0, 0, 1, 9, 32'h77,       1, 0, 0, 9, 0, 32'h77,       0, 0,            0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 9, 5, 0,            1, 32'hDEADBEEF, 0, 1));

    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check_outs($sformatf("v%0d", i), vq[i].e1d, vq[i].e1n, vq[i].e2d, vq[i].e2n, vq[i].eb);
    end

    // Asynchronous reset mid-cycle with live state (x5 data, x9 tagged).
    @(negedge clk);
    drive(idle);
    iDP_rs1_regnm = 5'd5;
    iDP_rs2_regnm = 5'd9;
    #1;
    check_outs("pre_rst", 32'hDEADBEEF, 0, 0, 1, 1);
    #1;
    rst = 1'b0;
    #1;
    check_outs("in_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_outs("post_rst", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Architectural register file plus rename-tag table; sits directly downstream of the reorder buffer.
- Takes the ROB's nick allocations (rd to nick mapping) and its in-order commit writebacks. Handles the ROB flush (clr) on branch mispredict.
- Serves two combinational source-operand lookups to dispatch. Each lookup returns either a ready value or the ROB nick that will produce it.

Parameters:
- DATA_W, 32, data width (DataBus)
- NAME_W, 5, architectural register index width (NameBus); 2**NAME_W registers
- NICK_W, 5, ROB nick width (NickBus); nick 0 = "no tag / value ready", valid nicks 1..31

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global enable; when low all state holds
- iROB_clr  input  1  ROB flush (mispredict commit)
- iROB_nick_en  input  1  rename allocation valid
- iROB_nick  input  NICK_W  nick allocated to the instruction's rd
- iROB_nick_regnm  input  NAME_W  architectural rd being renamed
- iRF_en  input  1  ROB commit writeback valid
- iRF_rd_regnm  input  NAME_W  committed destination register
- iRF_rd_dt  input  DATA_W  committed value
- iRF_rd_nick  input  NICK_W  nick of committing entry
- iDP_rs1_regnm  input  NAME_W  source 1 index
- iDP_rs2_regnm  input  NAME_W  source 2 index
- oDP_rs1_dt  output  DATA_W  source 1 value (valid when oDP_rs1_nick==0)
- oDP_rs1_nick  output  NICK_W  source 1 pending producer, 0 if ready
- oDP_rs2_dt  output  DATA_W  source 2 value
- oDP_rs2_nick  output  NICK_W  source 2 pending producer
- oRF_busy_cnt  output  NAME_W+1  number of registers currently tagged (registered)

Behaviour:
- Storage: dt[0..31] (DATA_W), tag[0..31] (NICK_W). x0 always reads dt=0, nick=0; writes and renames to x0 are ignored.
- Reset (rst==0, asynchronous):
  - all dt and tag cleared; oRF_busy_cnt=0.
  - Read outputs are combinational, so they read 0/0.
- Read ports (combinational, zero latency):
  - If tag[rs]==0: dt=dt[rs], nick=0.
  - Commit bypass: if iRF_en and iRF_rd_regnm==rs!=0 and tag[rs]==iRF_rd_nick, output dt=iRF_rd_dt, nick=0.
  - Otherwise: dt=dt[rs] (don't-care), nick=tag[rs].
  - Same-cycle rename does not affect reads. Sources see the mapping from before this cycle's rd rename.
  - While iROB_clr is high, reads are still computed normally; dispatch discards them.
- Sequential update, posedge clk, only when rdy==1:
  - Commit, when iRF_en and regnm!=0:
    - dt[regnm] <= iRF_rd_dt unconditionally (in-order commit guarantees it is the newest architected value).
    - tag[regnm] <= 0 only if tag[regnm]==iRF_rd_nick. A younger rename keeps its tag.
  - Rename, when iROB_nick_en, regnm!=0 and !iROB_clr: tag[regnm] <= iROB_nick.
    - Rename wins over a same-cycle commit tag-clear on the same register.
  - Flush, when iROB_clr: all tag[] <= 0.
    - The same-cycle commit dt write is still performed.
    - The same-cycle rename is dropped.
  - oRF_busy_cnt is updated to the post-edge number of nonzero tags. It is 0 the cycle after a flush.
- rdy==0: no state change; reads remain combinational from held state.
- iROB_nick==0 with iROB_nick_en=1 is illegal. A simulation assertion flags it.
- A nick value never appears in two tags at once; the ROB guarantees this.

Test Plan:
- Reset then read: drop rst to 0 mid-cycle -> outputs immediately 0/0; after release, rs1=5 reads dt=0, nick=0, busy_cnt=0.
- Rename then commit: rename x5->nick 3; next cycle rs1=5 reads nick=3. Commit x5, nick 3, data 0xDEADBEEF -> same-cycle bypass gives dt=0xDEADBEEF, nick=0. Next cycle the registered read matches; busy_cnt back to 0.
- Stale commit: rename x7->nick 4, then x7->nick 9. Commit x7, nick 4, data 0x11 -> dt[7]=0x11 but rs reads nick=9. Commit nick 9, data 0x22 -> reads 0x22, nick 0.
- Simultaneous rename and commit: x2 tagged 6. Same cycle: commit x2 nick 6 data 0x55 and rename x2->nick 7 -> next cycle nick=7, dt[2]=0x55. Same-cycle source read of x2 returns 0x55, nick 0 (bypass, pre-rename).
- Flush: tag x1->2, x3->5, x4->8. Assert clr with commit x1 nick 2 data 0xAA and rename x6->10 -> next cycle all nicks 0, dt[1]=0xAA, x6 untagged, busy_cnt=0.
- x0 and rdy: rename x0->nick 12 and commit x0 data 0xFF -> x0 reads 0/0. With rdy=0, rename x9->nick 1 -> x9 stays untagged.
